div_module: RTL and testbench
=============================

Name: div_module

Overview:
- Unsigned sequential divider. It is the inverse of the team's registered multiplier: it takes a product-width dividend and a narrow divisor and returns the quotient and remainder.
- Uses a restoring shift/subtract algorithm at one quotient bit per clock.
- Uses a start/busy/done handshake so it can sit beside the multiplier in datapath test structures.
- Has fixed latency, including the divide-by-zero case.

Parameters:
- A_W, 7, dividend and quotient width (matches the multiplier product width 4+3).
- B_W, 3, divisor and remainder width.
- CNT_W, $clog2(A_W+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- div_start  input  1  request pulse; operands are sampled when a start is accepted.
- div_a  input  A_W  unsigned dividend.
- div_b  input  B_W  unsigned divisor.
- div_busy  output  1  high while an iteration is in progress.
- div_done  output  1  single-cycle pulse; results are valid from this cycle onward.
- div_quot  output  A_W  quotient (registered).
- div_rem  output  B_W  remainder (registered).
- div_zero  output  1  divide-by-zero flag for the last completed operation (registered).

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; counter=0.
  - div_busy=0, div_done=0, div_quot=0, div_rem=0, div_zero=0.
  - Internal operand and partial-remainder registers are cleared to 0.
- States:
  - IDLE → CALC when div_start=1.
  - CALC → DONE when the counter reaches A_W-1 on the current edge, i.e. after A_W iterations.
  - DONE → CALC if div_start=1, giving back-to-back operation; otherwise DONE → IDLE.
- Start acceptance:
  - A start is accepted only in IDLE or DONE.
  - div_start while in CALC is ignored: no restart and no queueing.
  - On acceptance, capture div_a into the shift register, div_b into the divisor register, and clear the partial remainder (B_W+1 bits) and the counter.
- Iteration (one per cycle in CALC), on the B_W+1-bit partial remainder r:
  - r' = {r[B_W-1:0], dividend MSB}; shift the dividend left.
  - If r' >= divisor: r = r' - divisor and shift in quotient bit 1. Otherwise r = r' and shift in quotient bit 0.
  - The quotient accumulates in the vacated LSBs of the dividend register.
- Latency:
  - Start sampled at edge N.
  - div_busy=1 during the cycles following edges N..N+A_W-1.
  - Outputs are updated and div_done=1 for exactly one cycle following edge N+A_W, i.e. A_W+1 edges after the start edge.
- Output hold: div_busy=(state==CALC). div_quot, div_rem and div_zero update only at completion and hold their values until the next completion or reset.
- Divide by zero (div_b==0 at acceptance):
  - The iteration still runs, so latency is unchanged.
  - At completion force div_quot={A_W{1'b1}}, div_rem=0, div_zero=1.
  - Any nonzero divisor yields div_zero=0.
- Width rules:
  - Quotient fits A_W bits for every nonzero divisor.
  - Remainder < divisor, so it fits B_W bits; drop the MSB of r at output.
  - No saturation needed.
- Reset mid-operation: immediate abort to the reset values. No div_done is produced for the aborted operation.
- Operand stability: div_a and div_b may change freely after the accept edge; only the captured copies are used.

Decomposition:
- Package div_pkg:
  - State enum (IDLE, CALC, DONE; 2-bit).
  - Divide-by-zero quotient constant function/value (all ones).
- Sub-module div_step:
  - Purely combinational single restoring step.
  - Inputs: partial remainder, incoming bit, divisor.
  - Outputs: next remainder, quotient bit.
  - Instantiated once in div_module; this keeps the FSM/control separate from the arithmetic and gives a natural target for an exhaustive unit check.

Test Plan:
- 100/5 start pulse → div_done exactly 8 edges after the start edge; quot=20, rem=0, zero=0; busy high 7 cycles.
- 127/7 → quot=18, rem=1; then 0/3 → quot=0, rem=0.
- 5/0 → same latency; quot=127, rem=0, zero=1; a following 9/4 → quot=2, rem=1, zero=0.
- 99/7 started, then div_start with 50/2 pulsed at cycles 2 and 4 of CALC → ignored; result quot=14, rem=1; only one div_done.
- Back-to-back: start held high through the DONE cycle with 60/6 after 100/5 → second div_done 8 edges after the first; quot=10, rem=0.
- rst_n asserted mid-CALC at iteration 3 → all outputs 0 asynchronously; no div_done; a new 77/7 after release → quot=11, rem=0.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the unsigned restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_A_W = 7;
  localparam int DIV_B_W = 3;

  // All-ones pattern of the requested width, reported as the quotient on divide-by-zero.
  function automatic logic [31:0] div_zero_quot(input int unsigned w);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < w) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step #(
  parameter int B_W = div_pkg::DIV_B_W
) (
  input  logic [B_W:0]   rem_in,
  input  logic           bit_in,
  input  logic [B_W-1:0] divisor,
  output logic [B_W:0]   rem_out,
  output logic           quot_bit
);

  logic [B_W:0] shifted;
  logic [B_W:0] divisor_ext;

  assign shifted     = {rem_in[B_W-1:0], bit_in};
  assign divisor_ext = {1'b0, divisor};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rem_out  = shifted;
    quot_bit = 1'b0;
    if (shifted >= divisor_ext) begin
      rem_out  = shifted - divisor_ext;
      quot_bit = 1'b1;
    end
  end

endmodule

// File: rtl/div_module.sv
// Unsigned sequential divider, one quotient bit per clock, with start/busy/done handshake.
module div_module
  import div_pkg::*;
#(
  parameter int A_W = DIV_A_W,
  parameter int B_W = DIV_B_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           div_start,
  input  logic [A_W-1:0] div_a,
  input  logic [B_W-1:0] div_b,
  output logic           div_busy,
  output logic           div_done,
  output logic [A_W-1:0] div_quot,
  output logic [B_W-1:0] div_rem,
  output logic           div_zero
);

  localparam int CNT_W = $clog2(A_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(A_W - 1);
  localparam logic [A_W-1:0]   ZERO_QUOT = A_W'(div_zero_quot(A_W));

  div_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [A_W-1:0] shift_q, shift_d;
  logic [B_W-1:0] dvsr_q, dvsr_d;
  logic [B_W:0]   prem_q, prem_d;
  logic [A_W-1:0] quot_q, quot_d;
  logic [B_W-1:0] rem_q, rem_d;
  logic           zero_q, zero_d;

  logic [B_W:0]   step_rem;
  logic           step_bit;

  div_step #(.B_W(B_W)) u_step (
    .rem_in  (prem_q),
    .bit_in  (shift_q[A_W-1]),
    .divisor (dvsr_q),
    .rem_out (step_rem),
    .quot_bit(step_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    dvsr_d  = dvsr_q;
    prem_d  = prem_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    zero_d  = zero_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (div_start) begin
          state_d = CALC;
          cnt_d   = '0;
          shift_d = div_a;
          dvsr_d  = div_b;
          prem_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // Quotient bits fill the LSBs vacated by the dividend shift.
        shift_d = {shift_q[A_W-2:0], step_bit};
        prem_d  = step_rem;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          state_d = DONE;
          cnt_d   = '0;
          zero_d  = (dvsr_q == '0);
          quot_d  = (dvsr_q == '0) ? ZERO_QUOT : shift_d;
          rem_d   = (dvsr_q == '0) ? '0 : step_rem[B_W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, including operand and partial-remainder registers, is cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      dvsr_q  <= '0;
      prem_q  <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      dvsr_q  <= dvsr_d;
      prem_q  <= prem_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      zero_q  <= zero_d;
    end
  end

  assign div_busy = (state_q == CALC);
  assign div_done = (state_q == DONE);
  assign div_quot = quot_q;
  assign div_rem  = rem_q;
  assign div_zero = zero_q;

endmodule

// File: tb/tb_div_module.sv
// Directed-vector bench for div_module: latency, results, divide-by-zero, ignore, back-to-back, reset abort.
module tb_div_module;

  logic       clk;
  logic       rst_n;
  logic       div_start;
  logic [6:0] div_a;
  logic [2:0] div_b;
  logic       div_busy;
  logic       div_done;
  logic [6:0] div_quot;
  logic [2:0] div_rem;
  logic       div_zero;

  int total;
  int bad;

  div_module dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .div_start(div_start),
    .div_a    (div_a),
    .div_b    (div_b),
    .div_busy (div_busy),
    .div_done (div_done),
    .div_quot (div_quot),
    .div_rem  (div_rem),
    .div_zero (div_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Starts one operation; lat counts edges from the start edge (inclusive) to the edge
  // after which div_done is seen, busy_n counts cycles with div_busy high before that.
  task automatic run_op(input logic [6:0] a, input logic [2:0] b,
                        output int lat, output int busy_n);
    @(negedge clk);
    div_start = 1'b1;
    div_a     = a;
    div_b     = b;
    @(posedge clk);
    lat = 1;
    #1;
    div_start = 1'b0;
    div_a     = ~a;
    div_b     = ~b;
    busy_n    = div_busy ? 1 : 0;
    while (lat < 20) begin
      @(posedge clk);
      lat++;
      #1;
      if (div_done) break;
      if (div_busy) busy_n++;
    end
  endtask

  task automatic check_result(input string name, input logic [6:0] q, input logic [2:0] r,
                              input logic z);
    total++;
    if (div_quot !== q || div_rem !== r || div_zero !== z) begin
      bad++;
      $display("FAIL %s: got quot=%0d rem=%0d zero=%0b, expected quot=%0d rem=%0d zero=%0b",
               name, div_quot, div_rem, div_zero, q, r, z);
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    div_start = 1'b0;
    div_a     = '0;
    div_b     = '0;
    #1;
    total++;
    if (div_busy !== 1'b0 || div_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl: busy=%0b done=%0b, expected 0 0", div_busy, div_done);
    end
    check_result("reset_data", 7'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat, busy_n;
    run_op(7'd100, 3'd5, lat, busy_n);
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL basic_latency: got %0d edges, expected 8", lat);
    end
    total++;
    if (busy_n !== 7) begin
      bad++;
      $display("FAIL basic_busy: got %0d busy cycles, expected 7", busy_n);
    end
    check_result("div_100_5", 7'd20, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (div_done !== 1'b0 || div_busy !== 1'b0) begin
      bad++;
      $display("FAIL done_pulse: done=%0b busy=%0b one cycle later, expected 0 0",
               div_done, div_busy);
    end
    @(posedge clk);
    #1;
    check_result("hold_100_5", 7'd20, 3'd0, 1'b0);

    run_op(7'd127, 3'd7, lat, busy_n);
    check_result("div_127_7", 7'd18, 3'd1, 1'b0);
    run_op(7'd0, 3'd3, lat, busy_n);
    check_result("div_0_3", 7'd0, 3'd0, 1'b0);
  endtask

  task automatic test_div_zero;
    int lat, busy_n;
    run_op(7'd5, 3'd0, lat, busy_n);
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL zero_latency: got %0d edges, expected 8", lat);
    end
    check_result("div_5_0", 7'd127, 3'd0, 1'b1);
    run_op(7'd9, 3'd4, lat, busy_n);
    check_result("div_9_4", 7'd2, 3'd1, 1'b0);
  endtask

  task automatic test_ignore_start;
    int done_n, done_at;
    done_n  = 0;
    done_at = 0;
    @(negedge clk);
    div_start = 1'b1;
    div_a     = 7'd99;
    div_b     = 3'd7;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    for (int k = 2; k <= 13; k++) begin
      div_start = (k == 3 || k == 5);
      div_a     = 7'd50;
      div_b     = 3'd2;
      @(posedge clk);
      #1;
      if (div_done) begin
        done_n++;
        done_at = k;
      end
    end
    div_start = 1'b0;
    total++;
    if (done_n !== 1 || done_at !== 8) begin
      bad++;
      $display("FAIL ignore_done: got %0d done pulses (last at edge %0d), expected 1 at 8",
               done_n, done_at);
    end
    check_result("div_99_7", 7'd14, 3'd1, 1'b0);
  endtask

  task automatic test_back_to_back;
    int lat, busy_n, gap;
    run_op(7'd100, 3'd5, lat, busy_n);
    check_result("b2b_first", 7'd20, 3'd0, 1'b0);
    div_start = 1'b1;
    div_a     = 7'd60;
    div_b     = 3'd6;
    gap = 0;
    @(posedge clk);
    gap++;
    #1;
    div_start = 1'b0;
    total++;
    if (div_busy !== 1'b1) begin
      bad++;
      $display("FAIL b2b_accept: busy=%0b after DONE-cycle start, expected 1", div_busy);
    end
    while (gap < 20) begin
      @(posedge clk);
      gap++;
      #1;
      if (div_done) break;
    end
    total++;
    if (gap !== 8) begin
      bad++;
      $display("FAIL b2b_spacing: got %0d edges between done pulses, expected 8", gap);
    end
    check_result("div_60_6", 7'd10, 3'd0, 1'b0);
  endtask

  task automatic test_reset_abort;
    int lat, busy_n, done_n;
    done_n = 0;
    @(negedge clk);
    div_start = 1'b1;
    div_a     = 7'd100;
    div_b     = 3'd3;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if (div_busy !== 1'b0 || div_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_ctrl: busy=%0b done=%0b during reset, expected 0 0",
               div_busy, div_done);
    end
    check_result("abort_data", 7'd0, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (div_done || div_busy) done_n++;
    end
    total++;
    if (done_n !== 0) begin
      bad++;
      $display("FAIL abort_quiet: got %0d active cycles after abort, expected 0", done_n);
    end
    run_op(7'd77, 3'd7, lat, busy_n);
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL after_abort_latency: got %0d edges, expected 8", lat);
    end
    check_result("div_77_7", 7'd11, 3'd0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_basic;
    test_div_zero;
    test_ignore_start;
    test_back_to_back;
    test_reset_abort;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
